// File: rtl/servo_pos_ctrl_if.sv
// Command channel into the servo position controller.
// Handshake: a command transfers on every rising clk edge where cmd_valid and
// cmd_ready are both 1. The source holds cmd_valid and cmd_pw stable until that
// transfer edge. cmd_ready may fall at any time and never depends on cmd_valid.
// cmd_clamped is a one-cycle status pulse that follows the accepting edge.
interface servo_pos_ctrl_if #(
    parameter int W = 12
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_pw;
    logic         cmd_clamped;

    modport master (
        output cmd_valid,
        output cmd_pw,
        input  cmd_ready,
        input  cmd_clamped
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pw,
        output cmd_ready,
        output cmd_clamped
    );
endinterface

// File: rtl/servo_pos_ctrl.sv
// Servo position sequencer: accepts pulse-width targets, clamps them to the
// safe range, slews pulsewidth one bounded step per PWM frame, then holds for
// HOLD_FRAMES frames before pulsing done. Drives the pwm block's en/period/
// pulsewidth. Optional build macro SERVO_POS_CTRL_SWEEP_EN adds a `sweep`
// input that self-issues alternating PW_MAX / PW_MIN targets.
module servo_pos_ctrl #(
    parameter int W           = 12,
    parameter int PERIOD      = 2000,
    parameter int PW_MIN      = 100,
    parameter int PW_MAX      = 200,
    parameter int PW_INIT     = 150,
    parameter int STEP        = 1,
    parameter int HOLD_FRAMES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
`ifdef SERVO_POS_CTRL_SWEEP_EN
    input  logic                 sweep,
`endif
    servo_pos_ctrl_if.slave      cmd,
    output logic                 pwm_en,
    output logic [W-1:0]         period,
    output logic [W-1:0]         pulsewidth,
    output logic                 frame_tick,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE_L     = W'(1);
    localparam logic [W-1:0] PERIOD_L  = W'(PERIOD);
    localparam logic [W-1:0] PW_MIN_L  = W'(PW_MIN);
    localparam logic [W-1:0] PW_MAX_L  = W'(PW_MAX);
    localparam logic [W-1:0] PW_INIT_L = W'(PW_INIT);
    localparam logic [W-1:0] STEP_L    = W'(STEP);
    localparam logic [W-1:0] HOLD_L    = W'(HOLD_FRAMES);

    if (!(PW_MIN <= PW_INIT && PW_INIT <= PW_MAX && PW_MAX < PERIOD)) begin : g_bad_range
        $error("servo_pos_ctrl: parameters must satisfy PW_MIN <= PW_INIT <= PW_MAX < PERIOD");
    end
    if (PERIOD >= (1 << W) || HOLD_FRAMES >= (1 << W) || STEP < 1) begin : g_bad_width
        $error("servo_pos_ctrl: PERIOD/HOLD_FRAMES must fit in W bits and STEP must be >= 1");
    end

    state_t       state_q, state_d;
    logic [W-1:0] pw_q, pw_d;
    logic [W-1:0] target_q, target_d;
    logic [W-1:0] frame_cnt_q, frame_cnt_d;
    logic [W-1:0] hold_cnt_q, hold_cnt_d;
    logic         pwm_en_q, pwm_en_d;
    logic         done_q, done_d;
    logic         clamped_q, clamped_d;

    logic         tick_c;
    logic         sweep_req;
    logic         cmd_ready_c;
    logic         issue_c;
    logic [W-1:0] issue_pw;
    logic         issue_clamped;
    logic         ramp_up;
    logic [W-1:0] ramp_diff;
    logic [W-1:0] ramp_step;
    logic [W-1:0] pw_stepped;

`ifdef SERVO_POS_CTRL_SWEEP_EN
    // 1: the next self-issued sweep target is PW_MAX, 0: PW_MIN.
    logic         sweep_hi_q, sweep_hi_d;
    assign sweep_req = sweep;
`else
    assign sweep_req = 1'b0;
`endif

    // Frame counter runs 0..PERIOD-1 while enabled; tick marks the last clock.
    always_comb begin
        tick_c      = en && (frame_cnt_q == PERIOD_L - ONE_L);
        frame_cnt_d = '0;
        if (en && !tick_c) begin
            frame_cnt_d = frame_cnt_q + ONE_L;
        end
    end

    // Command selection: external command with clamping, or self-issued sweep target.
    always_comb begin
        cmd_ready_c   = en && (state_q == S_IDLE) && !sweep_req;
        issue_c       = cmd.cmd_valid && cmd_ready_c;
        issue_clamped = 1'b0;
        issue_pw      = cmd.cmd_pw;
        if (cmd.cmd_pw < PW_MIN_L) begin
            issue_pw      = PW_MIN_L;
            issue_clamped = 1'b1;
        end else if (cmd.cmd_pw > PW_MAX_L) begin
            issue_pw      = PW_MAX_L;
            issue_clamped = 1'b1;
        end
`ifdef SERVO_POS_CTRL_SWEEP_EN
        if (en && (state_q == S_IDLE) && sweep_req) begin
            issue_c       = 1'b1;
            issue_clamped = 1'b0;
            issue_pw      = sweep_hi_q ? PW_MAX_L : PW_MIN_L;
        end
`endif
    end

    // One ramp step toward target, limited to STEP and never past target.
    always_comb begin
        ramp_up    = target_q > pw_q;
        ramp_diff  = ramp_up ? (target_q - pw_q) : (pw_q - target_q);
        ramp_step  = (ramp_diff < STEP_L) ? ramp_diff : STEP_L;
        pw_stepped = ramp_up ? (pw_q + ramp_step) : (pw_q - ramp_step);
    end

    // Next-state logic for the IDLE/RAMP/HOLD sequencer and its datapath.
    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        target_d   = target_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        clamped_d  = 1'b0;
        pwm_en_d   = en;
`ifdef SERVO_POS_CTRL_SWEEP_EN
        sweep_hi_d = sweep_hi_q;
`endif
        if (!en) begin
            // Abort: keep the live pulse width and forget the old target.
            state_d    = S_IDLE;
            hold_cnt_d = '0;
            target_d   = pw_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_c) begin
                        target_d   = issue_pw;
                        clamped_d  = issue_clamped;
                        hold_cnt_d = '0;
                        state_d    = (issue_pw == pw_q) ? S_HOLD : S_RAMP;
`ifdef SERVO_POS_CTRL_SWEEP_EN
                        if (sweep_req) begin
                            sweep_hi_d = !sweep_hi_q;
                        end
`endif
                    end
                end
                S_RAMP: begin
                    // pulsewidth only moves on the frame-wrap edge.
                    if (tick_c) begin
                        pw_d = pw_stepped;
                        if (pw_stepped == target_q) begin
                            state_d    = S_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (HOLD_L == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (tick_c) begin
                        if (hold_cnt_q + ONE_L == HOLD_L) begin
                            state_d    = S_IDLE;
                            done_d     = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + ONE_L;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pw_q        <= PW_INIT_L;
            target_q    <= PW_INIT_L;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            pwm_en_q    <= 1'b0;
            done_q      <= 1'b0;
            clamped_q   <= 1'b0;
`ifdef SERVO_POS_CTRL_SWEEP_EN
            sweep_hi_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            pw_q        <= pw_d;
            target_q    <= target_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            pwm_en_q    <= pwm_en_d;
            done_q      <= done_d;
            clamped_q   <= clamped_d;
`ifdef SERVO_POS_CTRL_SWEEP_EN
            sweep_hi_q  <= sweep_hi_d;
`endif
        end
    end

    assign cmd.cmd_ready   = cmd_ready_c;
    assign cmd.cmd_clamped = clamped_q;
    assign pwm_en          = pwm_en_q;
    assign period          = PERIOD_L;
    assign pulsewidth      = pw_q;
    assign frame_tick      = tick_c;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_servo_pos_ctrl.sv
// Directed bench for servo_pos_ctrl. PERIOD is shortened so a full set of
// moves fits in a short run; expected pulse-width steps are queued when a
// command is accepted and popped as the DUT changes pulsewidth.
module tb_servo_pos_ctrl;

    localparam int W       = 12;
    localparam int PERIOD  = 250;
    localparam int PW_MIN  = 100;
    localparam int PW_MAX  = 200;
    localparam int PW_INIT = 150;
    localparam int STEP    = 1;
    localparam int HOLD    = 5;

    // Clock / reset / DUT
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         pwm_en;
    logic [W-1:0] period;
    logic [W-1:0] pulsewidth;
    logic         frame_tick;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;
`ifdef SERVO_POS_CTRL_SWEEP_EN
    logic         sweep = 1'b0;
`endif

    servo_pos_ctrl_if #(.W(W)) cmd_if ();

    servo_pos_ctrl #(
        .W(W), .PERIOD(PERIOD), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX),
        .PW_INIT(PW_INIT), .STEP(STEP), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
`ifdef SERVO_POS_CTRL_SWEEP_EN
        .sweep      (sweep),
`endif
        .cmd        (cmd_if),
        .pwm_en     (pwm_en),
        .period     (period),
        .pulsewidth (pulsewidth),
        .frame_tick (frame_tick),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           model_pw      = PW_INIT;
    logic [W-1:0] prev_pw       = W'(PW_INIT);
    int           exp_clamp_cnt = 0;
    int           clamp_cnt     = 0;
    int           done_cnt      = 0;
    int           since         = 0;
    bit           gap_valid     = 1'b0;
    int           hold_ticks    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score everything visible there.
    task automatic step();
        @(negedge clk);
        since++;
        if (pulsewidth !== prev_pw) begin
            if (exp_q.size() == 0) begin
                check("pw_unexpected_change", pulsewidth, prev_pw);
            end else begin
                check("pw_step", pulsewidth, exp_q.pop_front());
            end
            check("pw_in_range", (pulsewidth >= PW_MIN && pulsewidth <= PW_MAX), 1);
            prev_pw    = pulsewidth;
            hold_ticks = 0;
        end
        if (cmd_if.cmd_clamped) clamp_cnt++;
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", busy, 0);
            check("hold_frames", hold_ticks, HOLD);
        end
        if (frame_tick) begin
            if (gap_valid) check("frame_gap", since, PERIOD);
            since = 0;
            hold_ticks++;
        end
    endtask

    // cmd_valid/cmd_pw are already driven; wait for ready, queue the ramp, take the accept edge.
    task automatic accept_cmd(input int pw);
        int tgt;
        int budget;
        bit clamp;
        int v;
        tgt   = (pw < PW_MIN) ? PW_MIN : ((pw > PW_MAX) ? PW_MAX : pw);
        clamp = (tgt != pw);
        budget = 0;
        while (!cmd_if.cmd_ready && budget < 200) begin
            step();
            budget++;
        end
        check("cmd_ready_wait", cmd_if.cmd_ready, 1);
        v = model_pw;
        while (v != tgt) begin
            int d;
            int s;
            d = (tgt > v) ? tgt - v : v - tgt;
            s = (d < STEP) ? d : STEP;
            v = (tgt > v) ? v + s : v - s;
            exp_q.push_back(v[W-1:0]);
        end
        model_pw = tgt;
        if (clamp) exp_clamp_cnt++;
        hold_ticks = 0;
        step();
        check("cmd_clamped", cmd_if.cmd_clamped, clamp);
        check("busy_after_accept", busy, 1);
        check("done_is_pulse", done, 0);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic send_cmd(input int pw);
        cmd_if.cmd_pw    = pw[W-1:0];
        cmd_if.cmd_valid = 1'b1;
        accept_cmd(pw);
    endtask

    task automatic wait_done(input int max_cycles);
        int start;
        int n;
        bit ready_leak;
        start      = done_cnt;
        n          = 0;
        ready_leak = 1'b0;
        while (done_cnt == start && n < max_cycles) begin
            step();
            n++;
            if (cmd_if.cmd_ready && done_cnt == start) ready_leak = 1'b1;
        end
        check("done_seen", done_cnt - start, 1);
        check("pw_final", pulsewidth, model_pw);
        check("exp_q_empty", exp_q.size(), 0);
        check("clamp_count", clamp_cnt, exp_clamp_cnt);
        check("no_ready_while_busy", ready_leak, 0);
        check("ready_at_done", cmd_if.cmd_ready, 1);
    endtask

    initial begin
        int n;
        int d0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_pw    = '0;

        // 1. Reset and enable
        repeat (5) @(negedge clk);
        check("rst_pulsewidth", pulsewidth, PW_INIT);
        check("rst_pwm_en", pwm_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clamped", cmd_if.cmd_clamped, 0);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_cmd_ready", cmd_if.cmd_ready, 0);
        check("rst_state", state_dbg, 0);
        check("period", period, PERIOD);
        rst = 1'b1;
        step();
        en        = 1'b1;
        since     = 1;
        gap_valid = 1'b1;
        check("pwm_en_latency0", pwm_en, 0);
        step();
        check("pwm_en_latency1", pwm_en, 1);
        check("ready_idle", cmd_if.cmd_ready, 1);
        repeat (2 * PERIOD) step();

        // 2. Nominal move 150 -> 160
        send_cmd(160);
        wait_done(20 * PERIOD);

        // 5. Abort mid-ramp: back to 150, then head for 170 and drop en at 155
        send_cmd(150);
        wait_done(20 * PERIOD);
        send_cmd(170);
        n = 0;
        while (pulsewidth != 155 && n < 10 * PERIOD) begin
            step();
            n++;
        end
        check("abort_reached_155", pulsewidth, 155);
        en        = 1'b0;
        gap_valid = 1'b0;
        d0        = done_cnt;
        step();
        check("abort_busy", busy, 0);
        check("abort_state", state_dbg, 0);
        check("abort_pwm_en", pwm_en, 0);
        check("abort_ready", cmd_if.cmd_ready, 0);
        exp_q.delete();
        model_pw = 155;
        repeat (20) step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_pw_held", pulsewidth, 155);
        en        = 1'b1;
        since     = 1;
        gap_valid = 1'b1;
        step();
        check("reenable_ready", cmd_if.cmd_ready, 1);
        check("reenable_busy", busy, 0);
        repeat (2 * PERIOD) step();
        check("reenable_pw_held", pulsewidth, 155);

        // 3/4. Clamp high with a second command held during the ramp
        send_cmd(300);
        cmd_if.cmd_pw    = 12'd40;
        cmd_if.cmd_valid = 1'b1;
        wait_done(60 * PERIOD);
        accept_cmd(40);
        wait_done(120 * PERIOD);

        // 4. No-move command goes straight to HOLD
        send_cmd(100);
        check("nomove_state_hold", state_dbg, 2);
        wait_done(10 * PERIOD);
        check("nomove_pw", pulsewidth, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
